// File: rtl/aes_pkg.sv
// AES key-RAM shared types and sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_NR     = 11;          // round keys per schedule
  localparam int KEY_W      = 128;         // round key width
  localparam int KRAM_WW    = 64;          // write word width
  localparam int KRAM_NWORD = 2 * AES_NR;  // write words per schedule
  localparam int KRAM_DEPTH = 2 * AES_NR;  // entries per half-array (two banks)

  typedef logic [KEY_W-1:0]   round_key_t;
  typedef logic [3:0]         round_idx_t;
  typedef logic [KRAM_WW-1:0] kram_word_t;
  typedef logic [4:0]         kram_addr_t;
  typedef logic [4:0]         wr_cnt_t;

  // Flat storage address: bank 0 occupies rows 0..10, bank 1 rows 11..21.
  function automatic kram_addr_t kram_addr(input logic bank, input round_idx_t rnd);
    kram_addr_t a;
    a = {1'b0, rnd};
    if (bank) a = a + kram_addr_t'(AES_NR);
    return a;
  endfunction

endpackage

// File: rtl/aes_keyram_bank_mem.sv
// Round-key storage: 64-bit lo/hi arrays holding both banks, separate read/write address.
// Latency: write 1 cycle; read data registered, valid the cycle after rd_en.
// Backpressure: none; rd_data holds its last value while rd_en is low.
// Ports: clk, kill (async active-low, clears rd_data only), wr_en/wr_hi/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (128-bit {hi, lo}).
module aes_keyram_bank_mem
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       kill,
  input  logic       wr_en,
  input  logic       wr_hi,
  input  kram_addr_t wr_addr,
  input  kram_word_t wr_data,
  input  logic       rd_en,
  input  kram_addr_t rd_addr,
  output round_key_t rd_data
);

  kram_word_t mem_lo [KRAM_DEPTH];
  kram_word_t mem_hi [KRAM_DEPTH];

  // Array contents survive reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_hi) mem_hi[wr_addr] <= wr_data;
      else       mem_lo[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= {mem_hi[rd_addr], mem_lo[rd_addr]};
    end
  end

endmodule

// File: rtl/aes128_keyram_2key_switch.sv
// Double-buffered AES-128 round-key RAM: core reads active bank, expander writes the other.
// Latency: key_round_rd valid 1 cycle after key_ready; writes land 1 cycle after en_wr.
// Backpressure: none; bank swap is deferred until the read schedule is at round 0.
// Ports: clk, kill (async active-low), en_wr/key_round_wr (64-bit write words),
//        key_ready (next round key), switch_key (swap request), key_round_rd, key_idx.
module aes128_keyram_2key_switch
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         kill,
  input  logic         en_wr,
  input  logic [63:0]  key_round_wr,
  input  logic         key_ready,
  input  logic         switch_key,
  output logic [127:0] key_round_rd,
  output logic         key_idx
);

  wr_cnt_t    wr_cnt;
  logic       in_burst;
  logic       burst_bank;
  round_idx_t rd_cnt;
  logic       pend;

  logic       wr_bank;
  logic       sw_req;
  logic       sw_fire;

  // The bank is sampled from ~key_idx on the first word and then frozen, so a
  // swap landing mid-burst cannot split one schedule across two banks.
  assign wr_bank = in_burst ? burst_bank : ~key_idx;

  // A new pulse counts immediately, letting a swap fire on the edge it arrives.
  assign sw_req  = pend | switch_key;
  assign sw_fire = sw_req && (rd_cnt == '0);

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      wr_cnt     <= '0;
      in_burst   <= 1'b0;
      burst_bank <= 1'b0;
    end else if (en_wr) begin
      wr_cnt     <= (wr_cnt == wr_cnt_t'(KRAM_NWORD - 1)) ? '0 : wr_cnt + 1'b1;
      in_burst   <= 1'b1;
      burst_bank <= wr_bank;
    end else begin
      wr_cnt     <= '0;
      in_burst   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      rd_cnt <= '0;
    end else if (key_ready) begin
      rd_cnt <= (rd_cnt == round_idx_t'(AES_NR - 1)) ? '0 : rd_cnt + 1'b1;
    end
  end

  // The read on a swap edge uses the old key_idx because the memory read
  // address is taken from the register before it toggles.
  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      key_idx <= 1'b0;
      pend    <= 1'b0;
    end else if (sw_fire) begin
      key_idx <= ~key_idx;
      pend    <= 1'b0;
    end else begin
      pend    <= sw_req;
    end
  end

  aes_keyram_bank_mem u_mem (
    .clk     (clk),
    .kill    (kill),
    .wr_en   (en_wr),
    .wr_hi   (wr_cnt[0]),
    .wr_addr (kram_addr(wr_bank, wr_cnt[4:1])),
    .wr_data (key_round_wr),
    .rd_en   (key_ready),
    .rd_addr (kram_addr(key_idx, rd_cnt)),
    .rd_data (key_round_rd)
  );

endmodule

// File: tb/tb_aes128_keyram_2key_switch.sv
module tb_aes128_keyram_2key_switch;

  logic         clk = 1'b0;
  logic         kill;
  logic         en_wr;
  logic [63:0]  key_round_wr;
  logic         key_ready;
  logic         switch_key;
  logic [127:0] key_round_rd;
  logic         key_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]  w_lo;
    logic [63:0]  w_hi;
    logic [127:0] exp_rd;
  } vec_t;

  vec_t         tbl_seq   [11];
  vec_t         tbl_fips  [11];
  vec_t         tbl_fresh [11];
  logic [127:0] fips_bytes [11];

  always #5 clk = ~clk;

  aes128_keyram_2key_switch dut (
    .clk          (clk),
    .kill         (kill),
    .en_wr        (en_wr),
    .key_round_wr (key_round_wr),
    .key_ready    (key_ready),
    .switch_key   (switch_key),
    .key_round_rd (key_round_rd),
    .key_idx      (key_idx)
  );

  function automatic logic [127:0] byterev(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int which, input int w);
    vec_t v;
    case (which)
      0:       v = tbl_seq[w / 2];
      1:       v = tbl_fips[w / 2];
      default: v = tbl_fresh[w / 2];
    endcase
    return (w % 2 == 1) ? v.w_hi : v.w_lo;
  endfunction

  task automatic burst(input int which);
    for (int w = 0; w < 22; w++) begin
      en_wr = 1'b1;
      key_round_wr = word_of(which, w);
      tick();
    end
    en_wr = 1'b0;
    key_round_wr = '0;
    tick();
  endtask

  task automatic read_check(input string name, input logic [127:0] exp);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check128(name, key_round_rd, exp);
    repeat (3) tick();
  endtask

  task automatic do_switch(input logic exp_idx);
    switch_key = 1'b1;
    tick();
    switch_key = 1'b0;
    check1("switch_idx", key_idx, exp_idx);
  endtask

  initial begin
    fips_bytes[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fips_bytes[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    fips_bytes[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    fips_bytes[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    fips_bytes[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    fips_bytes[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    fips_bytes[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    fips_bytes[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    fips_bytes[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    fips_bytes[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    fips_bytes[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    for (int r = 0; r < 11; r++) begin
      logic [127:0] rk;
      tbl_seq[r].w_lo   = 64'(2 * r);
      tbl_seq[r].w_hi   = 64'(2 * r + 1);
      tbl_seq[r].exp_rd = {64'(2 * r + 1), 64'(2 * r)};
      rk = byterev(fips_bytes[r]);
      tbl_fips[r].w_lo   = rk[63:0];
      tbl_fips[r].w_hi   = rk[127:64];
      tbl_fips[r].exp_rd = rk;
      tbl_fresh[r].w_lo   = 64'h1000 + 64'(2 * r);
      tbl_fresh[r].w_hi   = 64'h1000 + 64'(2 * r + 1);
      tbl_fresh[r].exp_rd = {64'h1000 + 64'(2 * r + 1), 64'h1000 + 64'(2 * r)};
    end
    // Literal round keys as published, independent of the byte reversal above.
    tbl_fips[0].exp_rd  = 128'h0f0e0d0c0b0a09080706050403020100;
    tbl_fips[1].exp_rd  = 128'hfe76abd6f178a6dafa72afd2fd74aad6;
    tbl_fips[10].exp_rd = 128'hc5302b4d8ba707f3174a94e37f1d1113;

    kill = 1'b0;
    en_wr = 1'b0;
    key_round_wr = '0;
    key_ready = 1'b1;  // must be ignored during reset
    switch_key = 1'b0;
    repeat (3) tick();
    check128("reset_rd", key_round_rd, '0);
    check1("reset_idx", key_idx, 1'b0);
    key_ready = 1'b0;
    kill = 1'b1;
    tick();
    check128("post_reset_rd", key_round_rd, '0);

    // 1: counting burst into bank1, swap, read all rounds
    burst(0);
    check1("burst_idx0", key_idx, 1'b0);
    do_switch(1'b1);
    for (int r = 0; r < 11; r++) read_check($sformatf("t1_r%0d", r), tbl_seq[r].exp_rd);
    check1("t1_idx", key_idx, 1'b1);

    // 2: FIPS schedule into bank0 while bank1 is read
    burst(1);
    for (int r = 0; r < 11; r++) read_check($sformatf("t2_bank1_r%0d", r), tbl_seq[r].exp_rd);
    do_switch(1'b0);
    for (int r = 0; r < 11; r++) read_check($sformatf("t2_fips_r%0d", r), tbl_fips[r].exp_rd);

    // 3: switch 5 cycles into a sequence is deferred until round 10 wraps
    for (int c = 0; c <= 40; c++) begin
      key_ready  = (c % 4 == 0);
      switch_key = (c == 5);
      tick();
      if (c % 4 == 0) begin
        check128($sformatf("t3_r%0d", c / 4), key_round_rd, tbl_fips[c / 4].exp_rd);
        check1($sformatf("t3_idx_r%0d", c / 4), key_idx, 1'b0);
      end
    end
    key_ready = 1'b0;
    switch_key = 1'b0;
    tick();
    check1("t3_idx_after_wrap", key_idx, 1'b1);

    // 4: 12 pulses, the 12th wraps back to round 0
    for (int p = 0; p < 12; p++)
      read_check($sformatf("t4_p%0d", p), tbl_seq[p % 11].exp_rd);
    for (int r = 1; r < 11; r++) read_check($sformatf("t4_tail_r%0d", r), tbl_seq[r].exp_rd);

    // 5: key_ready together with a switch at rd_cnt==0 reads the old bank
    key_ready = 1'b1;
    switch_key = 1'b1;
    tick();
    key_ready = 1'b0;
    switch_key = 1'b0;
    check128("t5_old_bank_r0", key_round_rd, tbl_seq[0].exp_rd);
    check1("t5_idx", key_idx, 1'b0);
    repeat (3) tick();
    read_check("t5_new_bank_r1", tbl_fips[1].exp_rd);

    // 6: reset mid-burst and mid-read
    for (int w = 0; w < 5; w++) begin
      en_wr = 1'b1;
      key_round_wr = 64'hdead_0000 + 64'(w);
      tick();
    end
    #2;
    kill = 1'b0;
    #1;
    check128("t6_kill_rd", key_round_rd, '0);
    check1("t6_kill_idx", key_idx, 1'b0);
    en_wr = 1'b0;
    key_round_wr = '0;
    tick();
    kill = 1'b1;
    tick();
    for (int r = 0; r < 11; r++) read_check($sformatf("t6_retained_r%0d", r), tbl_fips[r].exp_rd);
    burst(2);
    do_switch(1'b1);
    for (int r = 0; r < 11; r++) read_check($sformatf("t6_fresh_r%0d", r), tbl_fresh[r].exp_rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
